knight_cmd_link: RTL
====================

Name: knight_cmd_link

Overview:
Knight-side endpoint of the Bluetooth/UART command link; it is the responder to the host-side command sender.
- Receives a 16-bit command as two UART bytes (high byte first), assembles them and presents the result with cmd_rdy.
- Transmits 8-bit response bytes (0x5A acknowledge, 0xA5 tour done) back to the host.
- Sits between the top-level RX/TX pins and the command processor.

Parameters:
BAUD_DIV, 2604, clocks per bit period (50 MHz / 19200 baud)
TO_CYCLES, 22'd2_500_000, inter-byte timeout in clocks (50 ms); stale high byte discarded

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
RX  input  1  serial in from host, idle high, asynchronous to clk
TX  output  1  serial out to host, idle high
cmd  output  16  assembled command {high byte, low byte}
cmd_rdy  output  1  command valid, held until cleared
clr_cmd_rdy  input  1  single-cycle pulse from consumer; clears cmd_rdy
resp  input  8  response byte to send
send_resp  input  1  single-cycle pulse; starts transmission of resp
resp_sent  output  1  high from end of stop bit until next send_resp
frm_err  output  1  one-cycle pulse on a bad stop bit

Behaviour:
Reset values:
- TX=1, cmd=0, cmd_rdy=0, resp_sent=0, frm_err=0.
- RX synchronizer flops preset to 1.
- All FSMs in IDLE, all counters 0.

Receiver:
- RX is double-flopped before use.
- FSM states: IDLE, START, DATA, STOP.
- IDLE->START on synchronized falling edge.
- START waits BAUD_DIV/2 clocks and re-samples. If RX=1 (glitch), return to IDLE. Otherwise go to DATA.
- DATA samples every BAUD_DIV clocks, 8 bits, LSB first, shift right.
- STOP samples once. If RX=1, raise a one-cycle internal byte_rdy. If RX=0, pulse frm_err and discard the byte.
- Either way STOP->IDLE.

Assembler:
- FSM states: WAIT_HI, WAIT_LO.
- WAIT_HI + byte_rdy: latch high byte and go to WAIT_LO. The timeout counter starts at 0.
- WAIT_LO + byte_rdy: cmd <= {hi, byte}, cmd_rdy <= 1 on the same edge, then go to WAIT_HI.
- WAIT_LO with counter reaching TO_CYCLES-1 and no byte: return to WAIT_HI. cmd and cmd_rdy are unchanged.
- A framing error in WAIT_LO returns to WAIT_HI.
- Latency: cmd_rdy rises 1 clock after the internal byte_rdy of the low byte.
- cmd_rdy clears on clr_cmd_rdy. It also clears when the start bit of a new high byte is detected, so a half-received command is never flagged valid.
- clr_cmd_rdy in the same cycle as the set: the set wins.
- cmd holds its value until the next complete command.

Transmitter:
- FSM states: IDLE, XMIT.
- send_resp in IDLE: load the 10-bit frame {1, resp, 0} and clear resp_sent. TX goes low on the next clock.
- Each bit is held exactly BAUD_DIV clocks.
- After 10 bits, go to IDLE with TX=1 and resp_sent=1.
- send_resp while in XMIT is ignored; the frame in progress is unchanged.
- Receive and transmit paths are fully independent (full duplex).

Reset mid-operation:
- Every frame in progress is aborted. TX returns to 1 asynchronously. A partial command is lost.

Arithmetic:
- Baud counter: 12 bits, reset to 0 at each bit boundary.
- Bit counter: 4 bits.
- Timeout counter: 22 bits, saturating.

Test Plan:
1. Host sends 0x40, 0x22 back-to-back -> cmd=0x4022 and cmd_rdy=1 within 21*BAUD_DIV clocks of the first start bit. Pulse clr_cmd_rdy -> cmd_rdy=0 next clock, cmd still 0x4022.
2. send_resp with resp=0xA5 -> TX low for BAUD_DIV clocks, then bits 1,0,1,0,0,1,0,1, then high; resp_sent=1 after 10*BAUD_DIV (±1) clocks. A second send_resp mid-frame (resp=0x5A) -> frame still 0xA5.
3. Send 0x20, wait longer than TO_CYCLES, then send 0x01, 0x02 -> cmd=0x0102 and no command containing 0x20 appears.
4. Low byte with stop bit forced 0 -> frm_err pulses once, cmd_rdy stays 0. The next full pair 0x3355 -> cmd=0x3355.
5. Host sends 0x12, 0x34 while the DUT transmits 0x5A -> cmd=0x1234 and the TX frame is 0x5A, both uncorrupted.
6. Assert rst_n low mid-way through the high byte and mid-way through a TX frame -> TX=1 immediately, cmd_rdy=0. After release, 0x4022 is received correctly.

Source files
------------

// File: rtl/knight_cmd_link_if.sv
// Serial link bundle between the host pins/command processor and the knight endpoint.
interface knight_cmd_link_if;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        frm_err;

    modport slave (
        input  RX, clr_cmd_rdy, resp, send_resp,
        output TX, cmd, cmd_rdy, resp_sent, frm_err
    );

    modport master (
        output RX, clr_cmd_rdy, resp, send_resp,
        input  TX, cmd, cmd_rdy, resp_sent, frm_err
    );
endinterface

// File: rtl/knight_cmd_link.sv
// Knight-side UART command endpoint: assembles 16-bit commands from byte pairs
// and serializes 8-bit responses back to the host, full duplex.
module knight_cmd_link #(
    parameter int          BAUD_DIV  = 2604,
    parameter logic [21:0] TO_CYCLES = 22'd2_500_000
) (
    input logic              clk,
    input logic              rst_n,
    knight_cmd_link_if.slave link
);

    localparam logic [11:0] BIT_END  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_END = 12'(BAUD_DIV / 2 - 1);
    localparam logic [21:0] TO_END   = TO_CYCLES - 22'd1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {WAIT_HI, WAIT_LO}                    asm_state_t;
    typedef enum logic       {TX_IDLE, TX_XMIT}                    tx_state_t;

    // ---------------- receiver ----------------
    logic        rx_ff1, rx_ff2, rx_ff3;
    logic        rx_fall;
    rx_state_t   rx_state;
    logic [11:0] rx_baud;
    logic [3:0]  rx_bits;
    logic [7:0]  rx_shift;
    logic        byte_rdy;
    logic        frm_err_q;
    logic        start_ok;

    // Presets keep a reset-time low on RX from looking like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1 <= 1'b1;
            rx_ff2 <= 1'b1;
            rx_ff3 <= 1'b1;
        end else begin
            rx_ff1 <= link.RX;
            rx_ff2 <= rx_ff1;
            rx_ff3 <= rx_ff2;
        end
    end

    assign rx_fall = rx_ff3 & ~rx_ff2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= RX_IDLE;
            rx_baud   <= '0;
            rx_bits   <= '0;
            rx_shift  <= '0;
            byte_rdy  <= 1'b0;
            frm_err_q <= 1'b0;
            start_ok  <= 1'b0;
        end else begin
            byte_rdy  <= 1'b0;
            frm_err_q <= 1'b0;
            start_ok  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= RX_START;
                        rx_baud  <= '0;
                    end
                end
                RX_START: begin
                    if (rx_baud == HALF_END) begin
                        rx_baud <= '0;
                        rx_bits <= '0;
                        if (rx_ff2) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            start_ok <= 1'b1;
                        end
                    end else begin
                        rx_baud <= rx_baud + 12'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_baud == BIT_END) begin
                        rx_baud  <= '0;
                        rx_shift <= {rx_ff2, rx_shift[7:1]};
                        rx_bits  <= rx_bits + 4'd1;
                        if (rx_bits == 4'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_baud <= rx_baud + 12'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_baud == BIT_END) begin
                        rx_baud  <= '0;
                        rx_bits  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_ff2) byte_rdy  <= 1'b1;
                        else        frm_err_q <= 1'b1;
                    end else begin
                        rx_baud <= rx_baud + 12'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- command assembler ----------------
    asm_state_t  asm_state;
    logic [7:0]  hi_q;
    logic [15:0] cmd_q;
    logic        cmd_rdy_q;
    logic [21:0] to_cnt;

    // The set in WAIT_LO is written last so it overrides a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state <= WAIT_HI;
            hi_q      <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            to_cnt    <= '0;
        end else begin
            if (link.clr_cmd_rdy) cmd_rdy_q <= 1'b0;
            case (asm_state)
                WAIT_HI: begin
                    if (start_ok) cmd_rdy_q <= 1'b0;
                    if (byte_rdy) begin
                        hi_q      <= rx_shift;
                        to_cnt    <= '0;
                        asm_state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (byte_rdy) begin
                        cmd_q     <= {hi_q, rx_shift};
                        cmd_rdy_q <= 1'b1;
                        asm_state <= WAIT_HI;
                    end else if (frm_err_q || to_cnt == TO_END) begin
                        asm_state <= WAIT_HI;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 22'd1;
                    end
                end
                default: asm_state <= WAIT_HI;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    tx_state_t   tx_state;
    logic [8:0]  tx_shift;
    logic [11:0] tx_baud;
    logic [3:0]  tx_bits;
    logic        tx_q;
    logic        resp_sent_q;

    // tx_q carries the bit on the wire; tx_shift holds the rest of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= TX_IDLE;
            tx_shift    <= '1;
            tx_baud     <= '0;
            tx_bits     <= '0;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                    if (link.send_resp) begin
                        tx_shift    <= {1'b1, link.resp};
                        tx_q        <= 1'b0;
                        tx_baud     <= '0;
                        tx_bits     <= '0;
                        resp_sent_q <= 1'b0;
                        tx_state    <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (tx_baud == BIT_END) begin
                        tx_baud <= '0;
                        if (tx_bits == 4'd9) begin
                            tx_q        <= 1'b1;
                            resp_sent_q <= 1'b1;
                            tx_state    <= TX_IDLE;
                        end else begin
                            tx_q     <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[8:1]};
                            tx_bits  <= tx_bits + 4'd1;
                        end
                    end else begin
                        tx_baud <= tx_baud + 12'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign link.TX        = tx_q;
    assign link.cmd       = cmd_q;
    assign link.cmd_rdy   = cmd_rdy_q;
    assign link.resp_sent = resp_sent_q;
    assign link.frm_err   = frm_err_q;

endmodule
